// File: rtl/calc_cmd_driver_if.sv
// Command, calculator-drive and response signals of calc_cmd_driver.
// master: the driver itself; slave: command source, calculator, response sink.
interface calc_cmd_driver_if #(
    parameter int DW    = 32,
    parameter int TAG_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode;
    logic [DW-1:0]     cmd_op1;
    logic [DW-1:0]     cmd_op2;
    logic              cmd_sel;
    logic [TAG_W-1:0]  cmd_tag;
    logic [2:0]        opcode;
    logic [DW-1:0]     op_in1;
    logic [DW-1:0]     op_in2;
    logic              op_in_sel;
    logic [2*DW-1:0]   result;
    logic              valid_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_result;
    logic              rsp_ok;
    logic [TAG_W-1:0]  rsp_tag;
    logic [3:0]        inflight;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
        input  cmd_sel, cmd_tag, result, valid_res, rsp_ready,
        output cmd_ready, opcode, op_in1, op_in2, op_in_sel,
        output rsp_valid, rsp_result, rsp_ok, rsp_tag, inflight
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
        output cmd_sel, cmd_tag, result, valid_res, rsp_ready,
        input  cmd_ready, opcode, op_in1, op_in2, op_in_sel,
        input  rsp_valid, rsp_result, rsp_ok, rsp_tag, inflight
    );
endinterface

// File: rtl/calc_cmd_driver.sv
// Calculator command driver: issue, fixed-latency tracker, in-order response FIFO.
// Optional CALC_DRV_STATS_EN adds saturating stat_issued/stat_fail counters.
module calc_cmd_driver #(
    parameter int DW        = 32,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic        calc_clock,
    input  logic        calc_rst_n,
`ifdef CALC_DRV_STATS_EN
    output logic [15:0] stat_issued,
    output logic [15:0] stat_fail,
`endif
    calc_cmd_driver_if.master bus
);
    localparam int AW   = $clog2(RSP_DEPTH);
    localparam int CW   = AW + 1;
    localparam int SW   = CW + 4;
    localparam int TAIL = LATENCY - 1;

    logic [1:0]         rst_sync;
    logic [CW-1:0]      occ;
    logic [3:0]         infl;
    logic [SW-1:0]      credit_sum;
    logic               legal;
    logic               issue;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic [2*DW-1:0]    push_res;

    logic [LATENCY-1:0] trk_vld;
    logic [LATENCY-1:0] trk_ill;
    logic [TAG_W-1:0]   trk_tag [LATENCY];

    logic [2*DW-1:0]    mem_res [RSP_DEPTH];
    logic               mem_ok  [RSP_DEPTH];
    logic [TAG_W-1:0]   mem_tag [RSP_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    // Opcodes 1..5 are the only ones the calculator understands
    always_comb begin
        legal = 1'b0;
        unique case (bus.cmd_opcode)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
    end

    assign credit_sum    = SW'(occ) + SW'(infl);
    assign bus.cmd_ready = rst_sync[1] && (credit_sum < SW'(RSP_DEPTH));
    assign issue         = bus.cmd_valid && bus.cmd_ready;
    assign push          = trk_vld[TAIL];
    assign push_ok       = ~trk_ill[TAIL] & bus.valid_res;
    assign push_res      = trk_ill[TAIL] ? '0 : bus.result;
    assign bus.rsp_valid = (occ != '0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_result = mem_res[rd_ptr];
    assign bus.rsp_ok     = mem_ok[rd_ptr];
    assign bus.rsp_tag    = mem_tag[rd_ptr];
    assign bus.inflight   = infl;

    // Two-flop release of reset before any command is accepted
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end

    // Calculator drive: load on legal issue, otherwise NOP with held operands
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            bus.opcode    <= 3'd0;
            bus.op_in1    <= '0;
            bus.op_in2    <= '0;
            bus.op_in_sel <= 1'b0;
        end else if (issue && legal) begin
            bus.opcode    <= bus.cmd_opcode;
            bus.op_in1    <= bus.cmd_op1;
            bus.op_in2    <= bus.cmd_op2;
            bus.op_in_sel <= bus.cmd_sel;
        end else begin
            bus.opcode    <= 3'd0;
        end
    end

    // Tracker shifts every cycle; tail stage marks the capture edge
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            trk_vld <= '0;
            trk_ill <= '0;
            for (int i = 0; i < LATENCY; i++) trk_tag[i] <= '0;
        end else begin
            trk_vld[0] <= issue;
            trk_ill[0] <= issue & ~legal;
            trk_tag[0] <= bus.cmd_tag;
            for (int i = LATENCY - 1; i > 0; i--) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_ill[i] <= trk_ill[i-1];
                trk_tag[i] <= trk_tag[i-1];
            end
        end
    end

    // Credit counts: issue moves a credit into flight, capture into the FIFO
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            infl <= 4'd0;
            occ  <= '0;
        end else begin
            infl <= infl + 4'(issue) - 4'(push);
            occ  <= occ + CW'(push) - CW'(pop);
        end
    end

    // Response FIFO storage and pointers; credits guarantee room on push
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_res[i] <= '0;
                mem_ok[i]  <= 1'b0;
                mem_tag[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_res[wr_ptr] <= push_res;
                mem_ok[wr_ptr]  <= push_ok;
                mem_tag[wr_ptr] <= trk_tag[TAIL];
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef CALC_DRV_STATS_EN
    // Saturating counters of accepted commands and failed responses
    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            stat_issued <= 16'd0;
            stat_fail   <= 16'd0;
        end else begin
            if (issue && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (push && !push_ok && stat_fail != 16'hFFFF)
                stat_fail <= stat_fail + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver with a one-cycle calculator model.
// Checks reset, ops, back-to-back, credits, illegal, overflow, mid-reset.
module tb_calc_cmd_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    calc_cmd_driver_if #(.DW(32), .TAG_W(4)) bus ();

`ifdef CALC_DRV_STATS_EN
    logic [15:0] stat_issued, stat_fail;
`endif

    calc_cmd_driver #(
        .DW(32), .LATENCY(2), .RSP_DEPTH(4), .TAG_W(4)
    ) dut (
        .calc_clock (clk),
        .calc_rst_n (rst_n),
`ifdef CALC_DRV_STATS_EN
        .stat_issued(stat_issued),
        .stat_fail  (stat_fail),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] calc(input logic [2:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] r;
        logic        ok;
        logic [31:0] x;
        r = 64'd0;
        ok = 1'b0;
        case (op)
            3'd1: begin r = {32'd0, a} + {32'd0, b}; ok = ~r[32]; end
            3'd2: begin r = {32'd0, a} * {32'd0, b}; ok = 1'b1; end
            3'd3: begin r = {32'd0, a - b}; ok = (a >= b); end
            3'd4: begin
                x = s ? a : b;
                for (longint i = 0; i * i <= longint'(x); i++) r = 64'(i);
                ok = 1'b1;
            end
            3'd5: begin
                ok = (b != 0);
                if (ok) r = {32'd0, a / b};
            end
            default: begin r = 64'd0; ok = 1'b0; end
        endcase
        return {ok, r};
    endfunction

    // Calculator model: result valid one cycle after the drive registers
    always @(posedge clk or negedge rst_n) begin
        logic [64:0] v;
        if (!rst_n) begin
            bus.result    <= '0;
            bus.valid_res <= 1'b0;
        end else begin
            v = calc(bus.opcode, bus.op_in1, bus.op_in2, bus.op_in_sel);
            bus.result    <= v[63:0];
            bus.valid_res <= v[64];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [31:0] a,
        input logic [31:0] b, input logic s, input logic [3:0] t);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_op1    = a;
        bus.cmd_op2    = b;
        bus.cmd_sel    = s;
        bus.cmd_tag    = t;
    endtask

    task automatic test_reset();
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 3'd0;
        bus.cmd_op1 = '0; bus.cmd_op2 = '0; bus.cmd_sel = 1'b0;
        bus.cmd_tag = '0; bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.opcode, bus.op_in1, bus.op_in2, bus.op_in_sel} !== 68'd0) begin
            errors++; $display("FAIL reset_drive: got %0h exp 0",
                {bus.opcode, bus.op_in1, bus.op_in2, bus.op_in_sel});
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag} !== 70'd0) begin
            errors++; $display("FAIL reset_rsp: got %0h exp 0",
                {bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag});
        end
        checks++;
        if ({bus.inflight, bus.cmd_ready} !== 5'd0) begin
            errors++; $display("FAIL reset_ready_inflight: got %0h exp 0",
                {bus.inflight, bus.cmd_ready});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 4) begin step(); n++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: got %b exp 1", bus.cmd_ready);
        end
        checks++;
        if (n < 1) begin
            errors++; $display("FAIL reset_sync: edges %0d exp >=1", n);
        end
    endtask

    task automatic test_sum();
        bus.rsp_ready = 1'b1;
        set_cmd(3'd1, 32'd5, 32'd7, 1'b0, 4'd3);
        step();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.opcode, bus.op_in1, bus.op_in2} !== {3'd1, 32'd5, 32'd7}) begin
            errors++; $display("FAIL sum_drive: got %0h exp %0h",
                {bus.opcode, bus.op_in1, bus.op_in2}, {3'd1, 32'd5, 32'd7});
        end
        checks++;
        if (bus.inflight !== 4'd1) begin
            errors++; $display("FAIL sum_inflight: got %0d exp 1", bus.inflight);
        end
        step();
        checks++;
        if (bus.opcode !== 3'd0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL sum_e1: opcode %0d rsp_valid %b exp 0 0",
                bus.opcode, bus.rsp_valid);
        end
        step();
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag} !==
            {1'b1, 64'd12, 1'b1, 4'd3}) begin
            errors++; $display("FAIL sum_rsp: got v%b r%0d ok%b t%0d exp v1 r12 ok1 t3",
                bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL sum_pop: got %b exp 0", bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd4};
        logic [31:0] a   [3] = '{32'd3, 32'd10, 32'd81};
        logic [31:0] b   [3] = '{32'd4, 32'd4, 32'd0};
        logic [63:0] exp_r [3] = '{64'd12, 64'd6, 64'd9};
        for (int k = 0; k < 3; k++) begin
            set_cmd(ops[k], a[k], b[k], 1'b1, 4'(k + 1));
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready%0d: got %b exp 1", k, bus.cmd_ready);
            end
            step();
        end
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag} !==
                {1'b1, exp_r[k], 1'b1, 4'(k + 1)}) begin
                errors++; $display("FAIL b2b_rsp%0d: got v%b r%0d ok%b t%0d exp r%0d t%0d",
                    k, bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag,
                    exp_r[k], k + 1);
            end
            step();
        end
    endtask

    task automatic test_credit();
        int idx;
        int got;
        logic rdy;
        bus.rsp_ready = 1'b0;
        idx = 0;
        set_cmd(3'd1, 32'd1, 32'd10, 1'b0, 4'd0);
        for (int c = 0; c < 8; c++) begin
            rdy = bus.cmd_ready;
            step();
            if (rdy) idx++;
            bus.cmd_op1 = 32'(idx + 1); bus.cmd_tag = 4'(idx);
            bus.cmd_valid = (idx < 6);
        end
        checks++;
        if (idx != 4) begin
            errors++; $display("FAIL credit_accepted: got %0d exp 4", idx);
        end
        checks++;
        if ({bus.cmd_ready, bus.inflight, bus.rsp_valid} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL credit_full: ready %b inflight %0d rsp_valid %b exp 0 0 1",
                bus.cmd_ready, bus.inflight, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if ({bus.rsp_result, bus.rsp_ok, bus.rsp_tag} !==
                    {64'(got + 11), 1'b1, 4'(got)}) begin
                    errors++; $display("FAIL credit_rsp%0d: got r%0d ok%b t%0d exp r%0d ok1 t%0d",
                        got, bus.rsp_result, bus.rsp_ok, bus.rsp_tag, got + 11, got);
                end
                got++;
            end
            rdy = bus.cmd_ready;
            step();
            if (rdy && bus.cmd_valid) idx++;
            bus.cmd_op1 = 32'(idx + 1); bus.cmd_tag = 4'(idx);
            bus.cmd_valid = (idx < 6);
        end
        checks++;
        if (got != 6 || idx != 6) begin
            errors++; $display("FAIL credit_drain: got %0d rsp %0d acc exp 6 6", got, idx);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [2:0]  ops [3] = '{3'd3, 3'd7, 3'd3};
        logic [31:0] a   [3] = '{32'd20, 32'd55, 32'd9};
        logic [31:0] b   [3] = '{32'd5, 32'd66, 32'd1};
        logic [3:0]  tg  [3] = '{4'd4, 4'd9, 4'd5};
        logic [63:0] er  [3] = '{64'd15, 64'd0, 64'd8};
        logic        eok [3] = '{1'b1, 1'b0, 1'b1};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_cmd(ops[k], a[k], b[k], 1'b0, tg[k]);
            step();
            if (k == 1) begin
                checks++;
                if ({bus.opcode, bus.op_in1} !== {3'd0, 32'd20}) begin
                    errors++; $display("FAIL illegal_drive: opcode %0d op1 %0d exp 0 20",
                        bus.opcode, bus.op_in1);
                end
            end
        end
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag} !==
                {1'b1, er[k], eok[k], tg[k]}) begin
                errors++; $display("FAIL illegal_rsp%0d: got v%b r%0d ok%b t%0d exp r%0d ok%b t%0d",
                    k, bus.rsp_valid, bus.rsp_result, bus.rsp_ok, bus.rsp_tag,
                    er[k], eok[k], tg[k]);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bus.rsp_ready = 1'b1;
        set_cmd(3'd1, 32'd1, 32'd2, 1'b0, 4'd7);
        step();
        set_cmd(3'd2, 32'd3, 32'd5, 1'b1, 4'd8);
        step();
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.opcode, bus.op_in1, bus.op_in2, bus.op_in_sel, bus.rsp_valid,
             bus.rsp_result, bus.rsp_ok, bus.rsp_tag, bus.inflight,
             bus.cmd_ready} !== 143'd0) begin
            errors++; $display("FAIL midrst_outputs: opc %0d op1 %0d rv %b inf %0d rdy %b exp 0",
                bus.opcode, bus.op_in1, bus.rsp_valid, bus.inflight, bus.cmd_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 4) begin
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_norsp: got %b exp 0", bus.rsp_valid);
            end
            step(); n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || n < 1) begin
            errors++; $display("FAIL midrst_ready: got %b after %0d edges exp 1", bus.cmd_ready, n);
        end
        repeat (3) begin
            step();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.inflight !== 4'd0) begin
                errors++; $display("FAIL midrst_idle: rv %b inf %0d exp 0 0",
                    bus.rsp_valid, bus.inflight);
            end
        end
    endtask

    task automatic test_overflow();
        bus.rsp_ready = 1'b1;
        set_cmd(3'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 4'd6);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if ({bus.rsp_valid, bus.rsp_ok, bus.rsp_tag} !== {1'b1, 1'b0, 4'd6}) begin
            errors++; $display("FAIL overflow_rsp: got v%b ok%b t%0d exp v1 ok0 t6",
                bus.rsp_valid, bus.rsp_ok, bus.rsp_tag);
        end
`ifdef CALC_DRV_STATS_EN
        checks++;
        if ({stat_issued, stat_fail} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL overflow_stats: issued %0d fail %0d exp 1 1",
                stat_issued, stat_fail);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_sum();
        test_back_to_back();
        test_illegal();
        test_credit();
        test_mid_reset();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
